// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID/EX control-bundle bit positions, register
// index width and the hazard controller state encoding.
package pipe_pkg;

    localparam int CTRL_W      = 6;
    localparam int CTRL_RD_MMU = 0;
    localparam int CTRL_WR_MMU = 1;
    localparam int CTRL_BYTE   = 2;
    localparam int CTRL_WR_REG = 3;
    localparam int CTRL_BR     = 4;
    localparam int CTRL_LD     = 5;

    localparam int REG_IDX_W   = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is read
// by the instruction in decode. Register 0 is hardwired and never conflicts.
module hazard_lu_detect #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 ld_ins,
    input  logic [REG_IDX_W-1:0] rd_index,
    input  logic [REG_IDX_W-1:0] rs1_index,
    input  logic [REG_IDX_W-1:0] rs2_index,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    output logic                 lu
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_nonzero = (rd_index != '0);
    assign rs1_hit    = rs1_used && (rs1_index == rd_index);
    assign rs2_hit    = rs2_used && (rs2_index == rd_index);
    assign lu         = ld_ins && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MMU stall freeze, taken-branch flush and load-use
// bubble for the IF/ID and ID/EX registers. Optional HAZARD_PERF_CNT_EN adds
// stall/flush event counters.
//
// Handshake: mem_req/mmu_ready behave as a valid/ready pair; an access is
// outstanding while mem_req=1 and completes in the cycle mmu_ready=1.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_IDX_W    = pipe_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CTRL_W-1:0]    idex_control,
    input  logic [REG_IDX_W-1:0] idex_rgD_index,
    input  logic [REG_IDX_W-1:0] id_rgS1_index,
    input  logic [REG_IDX_W-1:0] id_rgS2_index,
    input  logic                 id_rgS1_used,
    input  logic                 id_rgS2_used,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mmu_ready,
    output logic                 pc_write_enable,
    output logic                 if_id_write_enable,
    output logic                 id_ex_write_enable,
    output logic                 id_ex_bubble,
    output logic                 if_id_flush,
    output state_t               fsm_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;

    logic lu;
    logic stall;
    logic br;
    logic br_take_run;

    // Bundle bits consumed by later stages, not by hazard logic.
    logic unused_ctrl;
    assign unused_ctrl = ^idex_control[CTRL_WR_REG:CTRL_RD_MMU];

    hazard_lu_detect #(
        .REG_IDX_W (REG_IDX_W)
    ) u_lu_detect (
        .ld_ins    (idex_control[CTRL_LD]),
        .rd_index  (idex_rgD_index),
        .rs1_index (id_rgS1_index),
        .rs2_index (id_rgS2_index),
        .rs1_used  (id_rgS1_used),
        .rs2_used  (id_rgS2_used),
        .lu        (lu)
    );

    assign stall       = mem_req && !mmu_ready;
    assign br          = idex_control[CTRL_BR] && ex_branch_taken;
    assign br_take_run = (state == ST_RUN) && !stall && br;
    assign fsm_state   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_RUN: begin
                if (stall) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (br && (FLUSH_CYCLES > 1)) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            ST_MEM_WAIT: begin
                // Branch/load-use are acted on only in the completion cycle.
                if (mmu_ready) begin
                    if (br && (FLUSH_CYCLES > 1)) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FLUSH_LOAD;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    if (cnt <= 3'd1) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        id_ex_write_enable = 1'b0;
        id_ex_bubble       = 1'b0;
        if_id_flush        = 1'b0;
        if (reset) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else begin
            unique case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    // In MEM_WAIT only mmu_ready unfreezes; mem_req is implied.
                    if ((state == ST_RUN) ? stall : !mmu_ready) begin
                        pc_write_enable = 1'b0;
                    end else if (br) begin
                        pc_write_enable    = 1'b1;
                        if_id_write_enable = 1'b1;
                        id_ex_write_enable = 1'b1;
                        id_ex_bubble       = 1'b1;
                        if_id_flush        = 1'b1;
                    end else if (lu) begin
                        id_ex_write_enable = 1'b1;
                        id_ex_bubble       = 1'b1;
                    end else begin
                        pc_write_enable    = 1'b1;
                        if_id_write_enable = 1'b1;
                        id_ex_write_enable = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        pc_write_enable    = 1'b1;
                        if_id_write_enable = 1'b1;
                        id_ex_write_enable = 1'b1;
                        id_ex_bubble       = 1'b1;
                        if_id_flush        = 1'b1;
                    end
                end
                default: begin
                    pc_write_enable = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write_enable) stall_cycles <= stall_cycles + 32'd1;
            if (br_take_run)      flush_events <= flush_events + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = br_take_run;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write enables and bubble/flush controls of the IF/ID and ID/EX pipeline registers.
- It consumes the ID/EX control bundle: bit0 read_mmu, bit1 write_mmu, bit2 byte_select, bit3 write_reg, bit4 br_ins, bit5 ld_ins. It also consumes the ID/EX destination index.
- Detects load-use hazards, freezes the pipe while the MMU is busy, and flushes younger instructions after a taken branch resolved in EX.

Parameters:
- FLUSH_CYCLES, 1, number of cycles bubbles are injected after a taken branch (1..7).
- REG_IDX_W, 5, width of register indices.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- idex_control  in  6  control bundle currently held in ID/EX (bit map above).
- idex_rgD_index  in  REG_IDX_W  destination register held in ID/EX.
- id_rgS1_index  in  REG_IDX_W  source 1 of the instruction in decode.
- id_rgS2_index  in  REG_IDX_W  source 2 of the instruction in decode.
- id_rgS1_used  in  1  decode instruction reads source 1.
- id_rgS2_used  in  1  decode instruction reads source 2.
- ex_branch_taken  in  1  branch in EX resolved taken; valid only when idex_control[4]=1.
- mem_req  in  1  MEM stage has an outstanding read_mmu or write_mmu.
- mmu_ready  in  1  MMU completes the access this cycle.
- pc_write_enable  out  1  PC update enable.
- if_id_write_enable  out  1  IF/ID register write enable.
- id_ex_write_enable  out  1  ID/EX register write enable.
- id_ex_bubble  out  1  force ID/EX control inputs to 0 (NOP) this cycle.
- if_id_flush  out  1  clear IF/ID instruction to NOP this cycle.

Behaviour:
- State register: RUN, MEM_WAIT, FLUSH (2-bit encoding). Flush counter: 3 bits.
- Outputs are Mealy: decoded from the current state and the current inputs.
- Reset (asynchronous) sets state=RUN and counter=0.
- While reset is asserted:
  - all enables are 0;
  - id_ex_bubble=1;
  - if_id_flush=1.
- Load-use hazard (lu), defined as:
  - idex_control[5]=1,
  - idex_rgD_index≠0,
  - and (id_rgS1_used and S1 matches idex_rgD_index, or id_rgS2_used and S2 matches idex_rgD_index).
- Priority within a cycle: memory stall > branch flush > load-use.
- RUN:
  - If mem_req=1 and mmu_ready=0: all enables 0, bubble 0, flush 0; next state MEM_WAIT.
  - Else if idex_control[4]=1 and ex_branch_taken=1: pc_we=1, if_id_we=1, id_ex_we=1, if_id_flush=1, id_ex_bubble=1.
    - If FLUSH_CYCLES>1: next state FLUSH with counter=FLUSH_CYCLES-1.
    - Else: stay in RUN.
  - Else if lu: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_bubble=1. A single bubble resolves the hazard; stay in RUN.
  - Else: all enables 1, bubble 0, flush 0.
- MEM_WAIT:
  - All enables 0 until mmu_ready=1.
  - In the mmu_ready=1 cycle: enables 1, and the load-use/branch checks of RUN apply; next state RUN.
  - Branch and load-use conditions are held frozen and are not acted on until exit.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, all enables 1; counter decrements each cycle.
  - At counter=1, next state is RUN.
  - A mem_req with mmu_ready=0 in FLUSH freezes (all enables 0) without decrementing; the state stays FLUSH.
- A branch-taken arriving simultaneously with lu: the branch wins; the decode instruction is flushed, so no stall is needed.
- Index 0 never creates a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_events[31:0]:
  - stall_cycles increments on every cycle with pc_write_enable=0;
  - flush_events increments on each taken-branch detection in RUN;
  - both counters wrap at 2^32 and reset to 0.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - control-bit index constants CTRL_RD_MMU=0, CTRL_WR_MMU=1, CTRL_BYTE=2, CTRL_WR_REG=3, CTRL_BR=4, CTRL_LD=5;
  - the state enum;
  - REG_IDX_W.
- One sub-module, hazard_lu_detect, holds the combinational load-use comparator.
- FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: idex_control=6'b100001, idex_rgD_index=5, id_rgS2_index=5 with id_rgS2_used=1 -> one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle (ID/EX now NOP) all enables 1.
- Register 0 with the same setup and idex_rgD_index=0 -> no stall.
- MMU wait: mem_req=1, mmu_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, 1 on the 4th; state returns to RUN.
- Branch with FLUSH_CYCLES=2: idex_control[4]=1 and ex_branch_taken=1 -> if_id_flush=1 and id_ex_bubble=1 for exactly 2 cycles; a simultaneous lu yields no stall.
- Reset mid-operation: assert reset during MEM_WAIT -> outputs go immediately to enables 0, bubble 1, flush 1; after release, state is RUN.
- With HAZARD_PERF_CNT_EN: the scenarios above produce stall_cycles=4 and flush_events=1.
